// File: rtl/mem_dma.sv
// mem_dma: single-channel word-copy engine that moves 16-bit words over a shared memory bus.
// Defining MEM_DMA_FILL_EN adds fillMode/fillData so a transfer can write a constant pattern instead.
module mem_dma #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      srcAddr,
    input  logic [31:0]      dstAddr,
    input  logic [LEN_W-1:0] len,
`ifdef MEM_DMA_FILL_EN
    input  logic             fillMode,
    input  logic [15:0]      fillData,
`endif
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] remaining,
    output logic [31:0]      addr,
    output logic [15:0]      write,
    output logic             we,
    output logic             re,
    input  logic [15:0]      read,
    input  logic             ready,
    output logic [2:0]       fsm_state
);

    // Bus handshake: a re or we request is presented with addr and held unchanged until the
    // clk edge where ready=1 completes the beat; read data is valid one cycle after the read request.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        FIN     = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [31:0]      src, dst;
    logic [15:0]      buffer;
    logic             abort_seen;
    logic             fill_q;
    logic             fill_in;
    logic [15:0]      fill_data_in;
    logic [LEN_W-1:0] rem_dec;
    logic             accept;

    assign accept    = (state == IDLE) && start;
    assign rem_dec   = remaining - LEN_W'(1);
    assign fsm_state = state;

`ifdef MEM_DMA_FILL_EN
    assign fill_in      = fillMode;
    assign fill_data_in = fillData;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= 1'b0;
        end else if (accept) begin
            fill_q <= fillMode;
        end
    end
`else
    assign fill_in      = 1'b0;
    assign fill_data_in = 16'h0000;
    assign fill_q       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        re         = 1'b0;
        we         = 1'b0;
        addr       = 32'h0000_0000;
        write      = 16'h0000;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_next = FIN;
                    end else if (fill_in) begin
                        state_next = WR;
                    end else begin
                        state_next = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                re   = 1'b1;
                addr = src;
                if (ready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                re         = 1'b1;
                addr       = src;
                state_next = WR;
            end
            WR: begin
                we    = 1'b1;
                addr  = dst;
                write = buffer;
                if (ready) begin
                    // An abort arriving on the final beat itself still ends the transfer here.
                    if ((rem_dec == '0) || abort_seen || abort) begin
                        state_next = FIN;
                    end else if (fill_q) begin
                        state_next = WR;
                    end else begin
                        state_next = RD_ADDR;
                    end
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src        <= 32'h0000_0000;
            dst        <= 32'h0000_0000;
            remaining  <= '0;
            buffer     <= 16'h0000;
            abort_seen <= 1'b0;
        end else begin
            if (accept) begin
                src        <= srcAddr;
                dst        <= dstAddr;
                remaining  <= len;
                abort_seen <= 1'b0;
                if (fill_in) begin
                    buffer <= fill_data_in;
                end
            end else if (state != IDLE && abort) begin
                abort_seen <= 1'b1;
            end
            if (state == RD_DATA) begin
                buffer <= read;
            end
            if (state == WR && ready) begin
                src       <= src + 32'd1;
                dst       <= dst + 32'd1;
                remaining <= rem_dec;
            end
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: directed-vector bench for mem_dma with a transaction-level write scoreboard
// and a per-cycle bus monitor; define MEM_DMA_FILL_EN to include the fill-mode vector.
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] srcAddr;
    logic [31:0] dstAddr;
    logic [15:0] len;
    logic        fill_mode;
    logic [15:0] fill_data;
    logic        busy;
    logic        done;
    logic [15:0] remaining;
    logic [31:0] addr;
    logic [15:0] write;
    logic        we;
    logic        re;
    logic [15:0] read;
    logic        ready;
    logic [2:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_q[$];
    logic [31:0] read_log[$];
    logic [31:0] write_log[$];
    int          write_count = 0;
    int          re_count = 0;
    int          done_count = 0;
    int          model_len = 0;
    bit          mon_en = 1'b0;
    bit          prev_re = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [15:0] prev_write = '0;

    mem_dma #(.LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .srcAddr   (srcAddr),
        .dstAddr   (dstAddr),
        .len       (len),
`ifdef MEM_DMA_FILL_EN
        .fillMode  (fill_mode),
        .fillData  (fill_data),
`endif
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .addr      (addr),
        .write     (write),
        .we        (we),
        .re        (re),
        .read      (read),
        .ready     (ready),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Memory contents as a pure function of the word address.
    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[15:0] ^ a[31:16] ^ 16'h3C5A;
    endfunction

    // Memory slave: read data follows the presented address by one clock.
    always @(posedge clk) read <= mem_word(addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bus monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            check("re_we_exclusive", {63'd0, re & we}, 64'd0);
            if (!re && !we) check("idle_bus_zero", {16'd0, addr, write}, 64'd0);
            if (prev_stall) check("stall_hold", {15'd0, we, addr, write}, {15'd0, 1'b1, prev_addr, prev_write});
            if (busy) check("remaining_track", {48'd0, remaining}, {48'd0, 16'(model_len - write_count)});
            if (re && !prev_re) begin
                read_log.push_back(addr);
                re_count++;
            end
            if (we && ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {16'd0, addr, write}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("write_beat", {16'd0, addr, write}, {16'd0, exp_q.pop_front()});
                end
                write_log.push_back(addr);
                write_count++;
            end
            if (done) done_count++;
            prev_re    = re;
            prev_stall = we && !ready && !rst;
            prev_addr  = addr;
            prev_write = write;
        end
    end

    // ---------------- driver ----------------
    // Cycle k is the k-th cycle after the start-accepting edge; per-cycle inputs are applied
    // just after the edge that opens cycle k and observed at that cycle's falling edge.
    task automatic run_xfer(input string name, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input logic fm, input logic [15:0] fd,
                            input int n_wr, input int exp_done, input logic [15:0] exp_rem,
                            input int abort_cyc, input bit abort_with_start, input int restart_cyc,
                            input int stall_lo, input int stall_hi, input int rst_cyc);
        int done_cyc;
        for (int i = 0; i < n_wr; i++) begin
            logic [31:0] sa, da;
            sa = s + 32'(i);
            da = d + 32'(i);
            exp_q.push_back({da, fm ? fd : mem_word(sa)});
        end
        write_count = 0;
        re_count    = 0;
        done_count  = 0;
        model_len   = int'(n);
        read_log.delete();
        write_log.delete();

        @(posedge clk); #1;
        check({name, "_idle_before"}, {62'd0, busy, done}, 64'd0);
        start     = 1'b1;
        abort     = abort_with_start;
        srcAddr   = s;
        dstAddr   = d;
        len       = n;
        fill_mode = fm;
        fill_data = fd;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;

        done_cyc = -1;
        for (int k = 1; k <= 300; k++) begin
            abort = (k == abort_cyc);
            start = (k == restart_cyc);
            if (k == restart_cyc) begin
                srcAddr = 32'h1234_0000;
                dstAddr = 32'h5678_0000;
                len     = 16'd7;
            end
            ready = !(k >= stall_lo && k <= stall_hi);
            rst   = (k == rst_cyc);
            @(negedge clk);
            if (rst_cyc > 0 && k == rst_cyc + 1) begin
                check({name, "_rst_busy"}, {63'd0, busy}, 64'd0);
                check({name, "_rst_bus"}, {14'd0, we, re, addr, write}, 64'd0);
                check({name, "_rst_remaining"}, {48'd0, remaining}, 64'd0);
                break;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        ready = 1'b1;
        #1;
        if (rst_cyc == 0) begin
            check({name, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
            check({name, "_remaining"}, {48'd0, remaining}, {48'd0, exp_rem});
            check({name, "_done_pulses"}, 64'(done_count), 64'd1);
        end
        check({name, "_write_count"}, 64'(write_count), 64'(n_wr));
        check({name, "_exp_q_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- directed vectors ----------------
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        srcAddr   = '0;
        dstAddr   = '0;
        len       = '0;
        fill_mode = 1'b0;
        fill_data = '0;
        ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        check("reset_remaining", {48'd0, remaining}, 64'd0);
        check("reset_bus", {14'd0, we, re, addr, write}, 64'd0);
        mon_en = 1'b1;

        // Copy of 4 words: done at 3*4+1.
        run_xfer("copy4", 32'hD000_0000, 32'h1000_0000, 16'd4, 1'b0, 16'h0, 4, 13, 16'd0, 0, 1'b0, 0, 0, 0, 0);
        check("copy4_first_addr", {32'd0, write_log.size() > 0 ? write_log[0] : 32'hFFFF_FFFF}, 64'h1000_0000);
        check("copy4_last_addr", {32'd0, write_log.size() > 3 ? write_log[3] : 32'hFFFF_FFFF}, 64'h1000_0003);
        check("model_pin_word", {48'd0, mem_word(32'hD000_0000)}, 64'hEC5A);

        // Zero length: no bus activity, done in the first cycle after the start edge.
        run_xfer("zero_len", 32'h0000_4000, 32'h0000_8000, 16'd0, 1'b0, 16'h0, 0, 1, 16'd0, 0, 1'b0, 0, 0, 0, 0);
        check("zero_len_reads", 64'(re_count), 64'd0);

        // Address wrap on both pointers.
        run_xfer("wrap", 32'hFFFF_FFFF, 32'h0000_FFFF, 16'd2, 1'b0, 16'h0, 2, 7, 16'd0, 0, 1'b0, 0, 0, 0, 0);
        check("wrap_read_count", 64'(read_log.size()), 64'd2);
        check("wrap_read0", {32'd0, read_log.size() > 0 ? read_log[0] : 32'h1234_5678}, 64'hFFFF_FFFF);
        check("wrap_read1", {32'd0, read_log.size() > 1 ? read_log[1] : 32'h1234_5678}, 64'h0000_0000);
        check("wrap_write1", {32'd0, write_log.size() > 1 ? write_log[1] : 32'h1234_5678}, 64'h0001_0000);

        // Abort during word 3's RD_DATA (cycle 8): word 3 still written, done at cycle 10.
        run_xfer("abort", 32'h0000_0100, 32'h0000_0200, 16'd10, 1'b0, 16'h0, 3, 10, 16'd7, 8, 1'b0, 0, 0, 0, 0);

        // Start while busy is ignored.
        run_xfer("restart_ignored", 32'h0000_0300, 32'h0000_0400, 16'd2, 1'b0, 16'h0, 2, 7, 16'd0, 0, 1'b0, 2, 0, 0, 0);

        // Abort while idle is ignored.
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        run_xfer("idle_abort", 32'h0000_0500, 32'h0000_0600, 16'd2, 1'b0, 16'h0, 2, 7, 16'd0, 0, 1'b0, 0, 0, 0, 0);

        // Start and abort together: the abort is discarded.
        run_xfer("start_abort", 32'h0000_0700, 32'h0000_0800, 16'd2, 1'b0, 16'h0, 2, 7, 16'd0, 0, 1'b1, 0, 0, 0, 0);

        // WR stalled for cycles 3..7, beat completes in cycle 8, done at 9.
        run_xfer("stall", 32'h0000_0900, 32'h0000_0A00, 16'd1, 1'b0, 16'h0, 1, 9, 16'd0, 0, 1'b0, 0, 3, 7, 0);

        // Reset asserted in cycle 4 while WR is stalled: idle in cycle 5, no write beat.
        run_xfer("reset_mid_wr", 32'h0000_0B00, 32'h0000_0C00, 16'd2, 1'b0, 16'h0, 0, 0, 16'd0, 0, 1'b0, 0, 3, 20, 4);

`ifdef MEM_DMA_FILL_EN
        // Fill: one word per cycle, done at 3+1, no reads.
        run_xfer("fill", 32'h0000_0D00, 32'h0000_0E00, 16'd3, 1'b1, 16'hA5A5, 3, 4, 16'd0, 0, 1'b0, 0, 0, 0, 0);
        check("fill_reads", 64'(re_count), 64'd0);
        fill_mode = 1'b0;
`endif

        // Back to a normal copy after the reset.
        run_xfer("post_reset_copy", 32'h0000_0F00, 32'h0000_1000, 16'd3, 1'b0, 16'h0, 3, 10, 16'd0, 0, 1'b0, 0, 0, 0, 0);

        @(posedge clk); #1;
        check("final_idle", {62'd0, busy, done}, 64'd0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
